// File: rtl/mp64_extmem_ctrl_pkg.sv
// Shared types and helpers for the external-memory controller.
//   ext_state_e    : controller FSM states
//   ext_err_e      : completion status codes carried to the done/err pulse
//   burst_in_range : 1 when a burst ends inside the external window
package mp64_extmem_ctrl_pkg;

  localparam int unsigned EXT_MAX_BEATS = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWfill,
    StIssue,
    StWdata,
    StRdata,
    StResp
  } ext_state_e;

  typedef enum logic [1:0] {
    ErrNone,
    ErrRange,
    ErrTimeout
  } ext_err_e;

  // End address is computed two bits wider than the address so that a burst
  // near the top of the 24-bit space cannot wrap and look legal.
  function automatic logic burst_in_range(input logic [23:0] addr, input logic [3:0] len,
                                          input int unsigned ext_bytes);
    logic [25:0] end_addr;
    end_addr = {2'b00, addr} + (({22'd0, len} + 26'd1) << 3);
    return end_addr <= 26'(ext_bytes);
  endfunction

endpackage

// File: rtl/mp64_extmem_wbuf.sv
// Write-beat buffer: holds up to 16 64-bit beats of one write burst.
//   sys_clk, sys_rst : clock, synchronous active-high reset (empties the buffer)
//   clr              : empty the buffer (pointer back to 0)
//   push, push_data  : append one beat; ignored once full
//   rd_idx, rd_data  : asynchronous read of a stored beat
//   count            : beats currently stored (0..16)
module mp64_extmem_wbuf
  import mp64_extmem_ctrl_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        clr,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic [3:0]  rd_idx,
  output logic [63:0] rd_data,
  output logic [4:0]  count
);

  logic [63:0] mem_q [EXT_MAX_BEATS];
  logic [4:0]  wr_ptr_q;
  logic        push_ok;

  assign push_ok = push && (wr_ptr_q != 5'(EXT_MAX_BEATS));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      wr_ptr_q <= '0;
    end else if (push_ok) begin
      wr_ptr_q <= wr_ptr_q + 5'd1;
    end
  end

  // Storage needs no reset: only beats below wr_ptr_q are ever read.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[3:0]] <= push_data;
    end
  end

  assign rd_data = mem_q[rd_idx];
  assign count   = wr_ptr_q;

endmodule

// File: rtl/mp64_extmem_ctrl.sv
// Fabric-to-PHY bridge for 1..16-beat 64-bit bursts.
//   req_*          : burst request (addr 8-byte aligned internally, len = beats-1)
//   wd_*           : write beats, buffered before the PHY request is issued
//   rd_*           : read beats, one registered cycle per PHY beat, rd_last on the final one
//   done/err       : one-cycle completion pulse, err for range error or timeout
//   busy           : controller not idle
//   phy_*          : external-memory PHY port, one single-cycle phy_req per burst
// All outputs are registered. PHY_WLAT must be at least 2.
module mp64_extmem_ctrl
  import mp64_extmem_ctrl_pkg::*;
#(
  parameter int unsigned EXT_BYTES = 262144,
  parameter int unsigned PHY_WLAT  = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        req_wen,
  input  logic [3:0]  req_len,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [63:0] wd_data,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        phy_req,
  output logic [23:0] phy_addr,
  output logic        phy_wen,
  output logic [63:0] phy_wdata,
  output logic [3:0]  phy_burst_len,
  input  logic [63:0] phy_rdata,
  input  logic        phy_rvalid,
  input  logic        phy_ready
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);
  // phy_wdata is registered, so beat 0 is loaded one cycle ahead of its slot.
  localparam logic [CntW-1:0] WlatCnt = CntW'(PHY_WLAT - 2);

  ext_state_e      state_q;
  ext_err_e        err_code_q;
  logic [23:0]     addr_q;
  logic            wen_q;
  logic [3:0]      len_q;
  logic [4:0]      beat_q;
  logic [CntW-1:0] cnt_q;

  logic            req_ready_q, wd_ready_q, rd_valid_q, rd_last_q, done_q, err_q;
  logic [63:0]     rd_data_q, phy_wdata_q;
  logic            phy_req_q, phy_wen_q;
  logic [23:0]     phy_addr_q;
  logic [3:0]      phy_burst_len_q;

  logic            wbuf_push;
  logic [63:0]     wbuf_rd_data;
  logic [4:0]      wbuf_count;
  logic [4:0]      len_p1;

  assign wbuf_push = (state_q == StWfill) && wd_valid && wd_ready_q;
  assign len_p1    = {1'b0, len_q} + 5'd1;

  mp64_extmem_wbuf u_wbuf (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .clr       (state_q == StIdle),
    .push      (wbuf_push),
    .push_data (wd_data),
    .rd_idx    (beat_q[3:0]),
    .rd_data   (wbuf_rd_data),
    .count     (wbuf_count)
  );

  // Every state change also clears cnt_q; cnt_q otherwise free-runs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= StIdle;
      err_code_q      <= ErrNone;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      len_q           <= '0;
      beat_q          <= '0;
      cnt_q           <= '0;
      req_ready_q     <= 1'b0;
      wd_ready_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
      rd_last_q       <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      phy_req_q       <= 1'b0;
      phy_addr_q      <= '0;
      phy_wen_q       <= 1'b0;
      phy_wdata_q     <= '0;
      phy_burst_len_q <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      phy_req_q  <= 1'b0;
      cnt_q      <= cnt_q + CntW'(1);
      unique case (state_q)
        StIdle: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr & ~24'h7;
            wen_q       <= req_wen;
            len_q       <= req_len;
            beat_q      <= '0;
            err_code_q  <= ErrNone;
            state_q     <= StCheck;
            cnt_q       <= '0;
          end
        end
        StCheck: begin
          cnt_q <= '0;
          if (!burst_in_range(addr_q, len_q, EXT_BYTES)) begin
            err_code_q <= ErrRange;
            state_q    <= StResp;
          end else if (wen_q) begin
            wd_ready_q <= 1'b1;
            state_q    <= StWfill;
          end else begin
            state_q <= StIssue;
          end
        end
        StWfill: begin
          if (wbuf_push && (wbuf_count == {1'b0, len_q})) begin
            wd_ready_q <= 1'b0;
            state_q    <= StIssue;
            cnt_q      <= '0;
          end
        end
        StIssue: begin
          if (phy_req_q) begin
            // Strobe has been up for its single cycle: the PHY took it.
            state_q <= wen_q ? StWdata : StRdata;
            cnt_q   <= '0;
          end else if (phy_ready) begin
            phy_req_q       <= 1'b1;
            phy_addr_q      <= addr_q;
            phy_wen_q       <= wen_q;
            phy_burst_len_q <= len_q;
          end else if (cnt_q == CntMax) begin
            err_code_q <= ErrTimeout;
            state_q    <= StResp;
            cnt_q      <= '0;
          end
        end
        StWdata: begin
          if (beat_q == len_p1) begin
            state_q <= StResp;
            cnt_q   <= '0;
          end else if (cnt_q >= WlatCnt) begin
            phy_wdata_q <= wbuf_rd_data;
            beat_q      <= beat_q + 5'd1;
          end
        end
        StRdata: begin
          if (phy_rvalid) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= phy_rdata;
            beat_q     <= beat_q + 5'd1;
            cnt_q      <= '0;
            if (beat_q == {1'b0, len_q}) begin
              rd_last_q <= 1'b1;
              state_q   <= StResp;
            end
          end else if (cnt_q == CntMax) begin
            err_code_q <= ErrTimeout;
            state_q    <= StResp;
            cnt_q      <= '0;
          end
        end
        StResp: begin
          done_q  <= 1'b1;
          err_q   <= (err_code_q != ErrNone);
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign wd_ready      = wd_ready_q;
  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign rd_last       = rd_last_q;
  assign done          = done_q;
  assign err           = err_q;
  assign busy          = (state_q != StIdle);
  assign phy_req       = phy_req_q;
  assign phy_addr      = phy_addr_q;
  assign phy_wen       = phy_wen_q;
  assign phy_wdata     = phy_wdata_q;
  assign phy_burst_len = phy_burst_len_q;

endmodule

// File: tb/tb_mp64_extmem_ctrl.sv
// Directed bench for mp64_extmem_ctrl with a 2-cycle-latency PHY model over a
// 256 KiB backing array. Unwritten words read back as pat(word index).
module tb_mp64_extmem_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        req_valid, req_ready, req_wen;
  logic [23:0] req_addr;
  logic [3:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic        rd_valid, rd_last, done, err, busy;
  logic [63:0] rd_data;
  logic        phy_req, phy_wen, phy_ready;
  logic [23:0] phy_addr;
  logic [63:0] phy_wdata;
  logic [3:0]  phy_burst_len;
  bit   [63:0] phy_rdata;
  bit          phy_rvalid;

  always #5 sys_clk = ~sys_clk;

  mp64_extmem_ctrl dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wen       (req_wen),
    .req_len       (req_len),
    .wd_valid      (wd_valid),
    .wd_ready      (wd_ready),
    .wd_data       (wd_data),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_last       (rd_last),
    .done          (done),
    .err           (err),
    .busy          (busy),
    .phy_req       (phy_req),
    .phy_addr      (phy_addr),
    .phy_wen       (phy_wen),
    .phy_wdata     (phy_wdata),
    .phy_burst_len (phy_burst_len),
    .phy_rdata     (phy_rdata),
    .phy_rvalid    (phy_rvalid),
    .phy_ready     (phy_ready)
  );

  function automatic logic [63:0] pat(input int idx);
    return {32'hC0DE5A5A, 32'(idx)};
  endfunction

  function automatic int widx(input bit [23:0] a, input int k);
    return (int'(a[17:3]) + k) & 32'h7FFF;
  endfunction

  // PHY model: accepts phy_req while idle, moves beat k at the edge p_cnt == k+1.
  bit          phy_busy = 1'b0;
  bit          phy_wr = 1'b0;
  bit          hold_ready = 1'b0;
  bit   [23:0] p_addr;
  bit   [3:0]  p_len;
  int          p_cnt = 0;
  logic [63:0] mem [32768];
  bit          mem_wr [32768];

  assign phy_ready = !phy_busy && !hold_ready;

  always @(posedge sys_clk) begin
    phy_rvalid <= 1'b0;
    if (phy_busy) begin
      p_cnt <= p_cnt + 1;
      if (p_cnt >= 1) begin
        if (phy_wr) begin
          mem[widx(p_addr, p_cnt - 1)]    <= phy_wdata;
          mem_wr[widx(p_addr, p_cnt - 1)] <= 1'b1;
        end else begin
          phy_rvalid <= 1'b1;
          phy_rdata  <= mem_wr[widx(p_addr, p_cnt - 1)] ? mem[widx(p_addr, p_cnt - 1)]
                                                        : pat(widx(p_addr, p_cnt - 1));
        end
        if (p_cnt - 1 == int'(p_len)) phy_busy <= 1'b0;
      end
    end else if (phy_req && phy_ready) begin
      phy_busy <= 1'b1;
      phy_wr   <= phy_wen;
      p_addr   <= phy_addr;
      p_len    <= phy_burst_len;
      p_cnt    <= 0;
    end
  end

  // Monitor, sampled mid-cycle.
  int          cyc = 0, rd_n = 0, done_n = 0, done_cyc = 0, last_rd_cyc = 0;
  int          preq_n = 0, preq_bad = 0;
  logic        done_err;
  logic [23:0] preq_addr;
  logic [3:0]  preq_len;
  logic        preq_wen;
  logic [63:0] rd_log [64];
  logic        rd_last_log [64];

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (rd_valid && rd_n < 64) begin
      rd_log[rd_n]      <= rd_data;
      rd_last_log[rd_n] <= rd_last;
      rd_n              <= rd_n + 1;
      last_rd_cyc       <= cyc;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_err <= err;
      done_cyc <= cyc;
    end
    if (phy_req) begin
      preq_n    <= preq_n + 1;
      preq_addr <= phy_addr;
      preq_len  <= phy_burst_len;
      preq_wen  <= phy_wen;
      if (!phy_ready) preq_bad <= preq_bad + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic start_burst(input string tag, input logic [23:0] a, input logic w,
                             input logic [3:0] l, input logic [63:0] d0);
    int guard;
    int i;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check_eq({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_wen   = w;
    req_len   = l;
    tick();
    req_valid = 1'b0;
    if (w) begin
      i = 0;
      guard = 0;
      while (i <= int'(l) && guard < 100) begin
        wd_valid = 1'b1;
        wd_data  = d0 + 64'(i);
        if (wd_ready) i++;
        tick();
        guard++;
      end
      check_eq({tag, "_wbeats"}, 64'(i), 64'(l) + 64'd1);
      // One surplus beat offered: must not be taken.
      wd_data = '1;
      check_eq({tag, "_wd_extra"}, wd_ready, 0);
      tick();
      wd_valid = 1'b0;
    end
  endtask

  task automatic run_burst(input string tag, input logic [23:0] a, input logic w,
                           input logic [3:0] l, input logic [63:0] d0, input logic exp_err,
                           output int r0, output int p0);
    int n0;
    int guard;
    n0 = done_n;
    r0 = rd_n;
    p0 = preq_n;
    start_burst(tag, a, w, l, d0);
    guard = 0;
    while (done_n == n0 && guard < 1500) begin
      tick();
      guard++;
    end
    check_eq({tag, "_done"}, 64'(done_n - n0), 1);
    check_eq({tag, "_err"}, done_err, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, p0, n0, c0, guard;
    sys_rst   = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wen   = 1'b0;
    req_len   = '0;
    wd_valid  = 1'b0;
    wd_data   = '0;
    repeat (3) tick();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_phy_req", phy_req, 0);
    check_eq("rst_done", done, 0);
    sys_rst = 1'b0;
    tick();
    check_eq("rst_release_req_ready", req_ready, 1);

    // 1: write 4 beats, read them back
    run_burst("t1w", 24'h000100, 1'b1, 4'd3, 64'hA0, 1'b0, r0, p0);
    check_eq("t1w_preq_n", 64'(preq_n - p0), 1);
    check_eq("t1w_preq_wen", preq_wen, 1);
    for (int i = 0; i < 4; i++) check_eq("t1w_mem", mem[32 + i], 64'hA0 + 64'(i));
    run_burst("t1r", 24'h000100, 1'b0, 4'd3, 64'h0, 1'b0, r0, p0);
    check_eq("t1r_beats", 64'(rd_n - r0), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t1r_data", rd_log[r0 + i], 64'hA0 + 64'(i));
      check_eq("t1r_last", rd_last_log[r0 + i], (i == 3));
    end

    // 2: unaligned single-beat read
    run_burst("t2", 24'h000107, 1'b0, 4'd0, 64'h0, 1'b0, r0, p0);
    check_eq("t2_phy_addr", preq_addr, 24'h000100);
    check_eq("t2_beats", 64'(rd_n - r0), 1);
    check_eq("t2_data", rd_log[r0], 64'hA0);
    check_eq("t2_last", rd_last_log[r0], 1);
    check_eq("t2_done_lag", 64'(done_cyc - last_rd_cyc), 1);

    // 3: 16 beats ending exactly at the window top, then one beat past it
    run_burst("t3", 24'h03FF80, 1'b0, 4'd15, 64'h0, 1'b0, r0, p0);
    check_eq("t3_beats", 64'(rd_n - r0), 16);
    check_eq("t3_len", preq_len, 4'd15);
    check_eq("t3_first", rd_log[r0], pat(32'h7FF0));
    check_eq("t3_final", rd_log[r0 + 15], pat(32'h7FFF));
    check_eq("t3_last", rd_last_log[r0 + 15], 1);
    check_eq("t3_last_early", rd_last_log[r0 + 14], 0);
    run_burst("t3oor", 24'h040000, 1'b0, 4'd0, 64'h0, 1'b1, r0, p0);
    check_eq("t3oor_preq", 64'(preq_n - p0), 0);
    check_eq("t3oor_beats", 64'(rd_n - r0), 0);

    // 4: PHY never ready -> timeout, then recovery
    hold_ready = 1'b1;
    c0 = cyc;
    run_burst("t4", 24'h000100, 1'b0, 4'd0, 64'h0, 1'b1, r0, p0);
    check_eq("t4_preq", 64'(preq_n - p0), 0);
    check_eq("t4_elapsed_ok", (done_cyc - c0 >= 1025) && (done_cyc - c0 <= 1035), 1);
    hold_ready = 1'b0;
    run_burst("t4rel", 24'h000100, 1'b0, 4'd1, 64'h0, 1'b0, r0, p0);
    check_eq("t4rel_beats", 64'(rd_n - r0), 2);
    check_eq("t4rel_d0", rd_log[r0], 64'hA0);
    check_eq("t4rel_d1", rd_log[r0 + 1], 64'hA1);

    // 5: reset during WDATA at beat 2 of 8
    n0 = done_n;
    start_burst("t5", 24'h000200, 1'b1, 4'd7, 64'hB0);
    guard = 0;
    while (phy_wdata !== 64'hB2 && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("t5_beat2", phy_wdata, 64'hB2);
    sys_rst = 1'b1;
    tick();
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_req_ready", req_ready, 0);
    check_eq("t5_rst_wdata", phy_wdata, 0);
    check_eq("t5_rst_phy_req", phy_req, 0);
    sys_rst = 1'b0;
    tick();
    check_eq("t5_req_ready_after", req_ready, 1);
    check_eq("t5_no_done", 64'(done_n - n0), 0);
    run_burst("t5r", 24'h000100, 1'b0, 4'd0, 64'h0, 1'b0, r0, p0);
    check_eq("t5r_data", rd_log[r0], 64'hA0);
    check_eq("t5r_req_when_ready", 64'(preq_bad), 0);

    // 6: req_valid held for two back-to-back reads
    n0 = done_n;
    r0 = rd_n;
    p0 = preq_n;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    req_valid = 1'b1;
    req_addr  = 24'h000108;
    req_wen   = 1'b0;
    req_len   = 4'd0;
    guard = 0;
    while (done_n - n0 < 2 && guard < 200) begin
      tick();
      guard++;
    end
    req_valid = 1'b0;
    repeat (10) tick();
    check_eq("t6_done_n", 64'(done_n - n0), 2);
    check_eq("t6_preq_n", 64'(preq_n - p0), 2);
    check_eq("t6_beats", 64'(rd_n - r0), 2);
    check_eq("t6_d0", rd_log[r0], 64'hA1);
    check_eq("t6_d1", rd_log[r0 + 1], 64'hA1);
    check_eq("t6_req_when_ready", 64'(preq_bad), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
